// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared encodings for the pipeline hazard controller: per-boundary
// commands, FSM states and a debug view of the controller state.
package pipe_ctrl_gen_pkg;

  // Command issued to one boundary register each cycle.
  typedef enum logic [1:0] {
    CTRL_STATE_DEFAULT = 2'b00,  // load next value
    CTRL_STATE_BLOCK   = 2'b01,  // hold
    CTRL_STATE_BUBBLE  = 2'b10,  // load a NOP
    CTRL_STATE_BRANCH  = 2'b11   // PC boundary only: load pc_new_o
  } ctrl_cmd_e;

  // Controller FSM states. REDIR_WAIT means a redirect target is parked
  // in pend_pc until the fetch unit finishes its outstanding miss.
  typedef enum logic {
    PCTRL_RUN        = 1'b0,
    PCTRL_REDIR_WAIT = 1'b1
  } pctrl_state_e;

  // Width of a boundary index; never zero so tiny configurations still
  // have a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_stall_prio.sv
// Highest-set-bit encoder: reports the index of the most significant
// asserted stall request (the stall level) and whether any bit is set.
module pipe_stall_prio
  import pipe_ctrl_gen_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan upward so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o   = i[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard controller. Every cycle it issues one 2-bit command per
// boundary register from the stall requests, the fetch-busy flag and a
// redirect from a resolving stage. A redirect that arrives while fetch is
// busy is parked in pend_pc and replayed as BRANCH once fetch goes idle.
// Two saturating counters track stall cycles and accepted redirects.
//
// Handshake: redirect_i is a level request held by the producer until
// accepted; acceptance is the combinational decision made this cycle
// (no separate ready output), and an unaccepted cycle has no side effect.
module pipe_ctrl_gen
  import pipe_ctrl_gen_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int ADDR_W   = 64,
  parameter bit DECOUPLE = 1'b0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_busy_i,
  input  logic [NSTAGE-1:0]         stall_req_i,
  input  logic                      redirect_i,
  input  logic [$clog2(NSTAGE)-1:0] redirect_stage_i,
  input  logic [ADDR_W-1:0]         redirect_pc_i,
  input  logic                      clr_cnt_i,
  output logic [2*NSTAGE-1:0]       ctrl_o,
  output logic [ADDR_W-1:0]         pc_new_o,
  output logic                      redirect_pending_o,
  output logic [CNT_W-1:0]          stall_cycles_o,
  output logic [CNT_W-1:0]          flush_cnt_o
);

  localparam int IW = $clog2(NSTAGE);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pctrl_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [NSTAGE-1:0] stall_vec;
  logic [IW-1:0]     stall_lvl;
  logic              stall_any;
  logic              accept;

  // Fetch-busy is folded into the PC boundary's stall request.
  always_comb begin
    stall_vec    = stall_req_i;
    stall_vec[0] = stall_req_i[0] | fetch_busy_i;
  end

  pipe_stall_prio #(
    .N  (NSTAGE),
    .IW (IW)
  ) u_prio (
    .req_i   (stall_vec),
    .idx_o   (stall_lvl),
    .valid_o (stall_any)
  );

  // Command generation and next-state: stall commands first, then the
  // REDIR_WAIT overrides, then an accepted redirect overrides both.
  always_comb begin
    ctrl_o      = '0;
    pc_new_o    = redirect_pc_i;
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    accept      = 1'b0;

    // Stall commands.
    for (int k = 0; k < NSTAGE; k++) begin
      if (!DECOUPLE) begin
        ctrl_o[2*k +: 2] = stall_any ? CTRL_STATE_BLOCK : CTRL_STATE_DEFAULT;
      end else if (stall_any && (k <= int'(stall_lvl))) begin
        ctrl_o[2*k +: 2] = CTRL_STATE_BLOCK;
      end else if (stall_any && (k == int'(stall_lvl) + 1)) begin
        ctrl_o[2*k +: 2] = CTRL_STATE_BUBBLE;
      end else begin
        ctrl_o[2*k +: 2] = CTRL_STATE_DEFAULT;
      end
    end

    // Parked redirect: discard the stale fetch and branch once fetch idles.
    if (state_q == PCTRL_REDIR_WAIT) begin
      pc_new_o = pend_pc_q;
      if (NSTAGE > 1) ctrl_o[3:2] = CTRL_STATE_BUBBLE;
      if (fetch_busy_i) begin
        ctrl_o[1:0] = CTRL_STATE_BLOCK;
      end else begin
        ctrl_o[1:0] = CTRL_STATE_BRANCH;
        state_d     = PCTRL_RUN;
      end
    end

    // A redirect is only taken when no stall sits at or above its stage.
    if (DECOUPLE) accept = redirect_i && (!stall_any || (stall_lvl < redirect_stage_i));
    else          accept = redirect_i && !stall_any;

    if (accept) begin
      for (int k = 1; k < NSTAGE; k++) begin
        if (k <= int'(redirect_stage_i)) ctrl_o[2*k +: 2] = CTRL_STATE_BUBBLE;
      end
      if (fetch_busy_i) begin
        ctrl_o[1:0] = CTRL_STATE_BLOCK;
        pend_pc_d   = redirect_pc_i;
        state_d     = PCTRL_REDIR_WAIT;
      end else begin
        ctrl_o[1:0] = CTRL_STATE_BRANCH;
        pc_new_o    = redirect_pc_i;
        state_d     = PCTRL_RUN;
      end
    end
  end

  // Saturating counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((state_q == PCTRL_RUN) && (ctrl_o[1:0] == CTRL_STATE_BLOCK) &&
          (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (accept && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  // State, parked target and counters; reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PCTRL_RUN;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign redirect_pending_o = (state_q == PCTRL_REDIR_WAIT);
  assign stall_cycles_o     = stall_cnt_q;
  assign flush_cnt_o        = flush_cnt_q;

endmodule
